cordic_job_ctrl: RTL
====================

// Module: cordic_job_ctrl
// PURPOSE
//  Initiator-side sequencer for the recon CORDIC core. Accepts one operand set
//  (X,Y,Z,m) per valid/ready handshake and drives recon's Xo/Yo/Zo/m/reset
//  inputs. It holds recon in reset, releases it for ITERS cycles, then captures
//  Xout/Yout/Zout and presents them on a valid/ready response port to the NN datapath.
// PARAMETERS
//  WIDTH    15  MSB index of every data bus (buses are [WIDTH:0], Q5.10 fixed point)
//  ITERS    16  cycles recon runs after reset release before outputs are final
//  RST_CYC  2   cycles cordic_reset is held high with operands stable (>=1)
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        synchronous, active-low reset
//  req_valid    in   1        request operands valid
//  req_ready    out  1        controller can accept a request
//  req_m        in   1        CORDIC mode bit forwarded to recon m
//  req_x        in   WIDTH+1  X operand
//  req_y        in   WIDTH+1  Y operand
//  req_z        in   WIDTH+1  Z operand
//  cordic_reset out  1        active-high reset to recon
//  cordic_m     out  1        mode to recon
//  cordic_x     out  WIDTH+1  to recon Xo
//  cordic_y     out  WIDTH+1  to recon Yo
//  cordic_z     out  WIDTH+1  to recon Zo
//  cordic_xout  in   WIDTH+1  from recon Xout
//  cordic_yout  in   WIDTH+1  from recon Yout
//  cordic_zout  in   WIDTH+1  from recon Zout
//  rsp_valid    out  1        result valid
//  rsp_ready    in   1        consumer accepts result
//  rsp_x        out  WIDTH+1  captured Xout
//  rsp_y        out  WIDTH+1  captured Yout
//  rsp_z        out  WIDTH+1  captured Zout
//  busy         out  1        high in LOAD/RUN/DONE
//  job_cnt      out  16       completed jobs (rsp handshakes), wraps 0xFFFF->0
// BEHAVIOUR
//  - reset==0 at edge: state IDLE, cnt=0, cordic_reset=1, cordic_m/x/y/z=0,
//    rsp_valid=0, rsp_x/y/z=0, job_cnt=0, busy=0. Applies in any state (aborts job).
//  - FSM IDLE->LOAD->RUN->DONE->IDLE. All outputs registered or decoded from state only.
//  - IDLE: req_ready=1, cordic_reset=1. On req_valid&req_ready: latch req_* into
//    cordic_*, cnt=0, go LOAD. Operands are held constant until the next accept;
//    req_* changes outside acceptance are ignored.
//  - LOAD: cordic_reset=1 for RST_CYC cycles (cnt counts up). Then cnt=0 -> RUN.
//  - RUN: cordic_reset=0 for ITERS cycles. On the edge ending the ITERS-th cycle:
//    capture cordic_xout/yout/zout into rsp_x/y/z, rsp_valid=1, cordic_reset=1, -> DONE.
//  - Latency: rsp_valid rises RST_CYC+ITERS clocks after the accepting edge (18 at defaults).
//  - DONE: rsp_valid and rsp_* held stable while rsp_ready=0 (indefinite stall allowed).
//    On rsp_valid&rsp_ready: rsp_valid=0, job_cnt+=1 (mod 2^16), -> IDLE.
//  - req_ready=1 only in IDLE; no request is accepted in the DONE handshake cycle.
//    Minimum job period is RST_CYC+ITERS+2 cycles.
//  - busy = (state!=IDLE). cnt width = clog2(max(ITERS,RST_CYC))+1; no overflow.
//  - Data is passed through bit-exactly. The block performs no arithmetic on X/Y/Z.
// TESTING  (stub recon: after reset release, Xout=Zo, Yout=Xo, Zout=Yo)
//  1 reset=0 for 3 clk -> cordic_reset=1, rsp_valid=0, req_ready=1, job_cnt=0.
//  2 req X=0x04D4 Y=0x0000 Z=0x0320 m=1, rsp_ready=1 -> rsp_valid 18 clk later,
//    rsp_x=0x0320 rsp_y=0x04D4 rsp_z=0x0000. cordic_reset low exactly 16 cycles. job_cnt=1.
//  3 rsp_ready=0 for 10 clk after rsp_valid -> rsp_* stable, req_ready=0, then
//    handshake -> IDLE, job_cnt increments once.
//  4 req_x toggled to 0xFFFF during RUN -> cordic_x stays 0x04D4, result unchanged.
//  5 reset=0 mid-RUN (cycle 8) -> next edge IDLE, rsp_valid=0, job_cnt unchanged.
//    A new job then completes normally.
//  6 back-to-back: req_valid held high, rsp_ready=1, 3 jobs (0x02C0/0x00C0/0x03A0,...) ->
//    accepts spaced 20 clk, results in order, job_cnt=3.

Source files
------------

// File: rtl/cordic_job_ctrl.sv
// Job sequencer for the recon CORDIC core. It latches one operand set, pulses
// recon's reset, lets recon run for a fixed number of cycles, then holds the result.
module cordic_job_ctrl #(
  parameter int WIDTH   = 15,
  parameter int ITERS   = 16,
  parameter int RST_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_m,
  input  logic [WIDTH:0]   req_x,
  input  logic [WIDTH:0]   req_y,
  input  logic [WIDTH:0]   req_z,
  output logic             cordic_reset,
  output logic             cordic_m,
  output logic [WIDTH:0]   cordic_x,
  output logic [WIDTH:0]   cordic_y,
  output logic [WIDTH:0]   cordic_z,
  input  logic [WIDTH:0]   cordic_xout,
  input  logic [WIDTH:0]   cordic_yout,
  input  logic [WIDTH:0]   cordic_zout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   rsp_x,
  output logic [WIDTH:0]   rsp_y,
  output logic [WIDTH:0]   rsp_z,
  output logic             busy,
  output logic [15:0]      job_cnt
);

  localparam int CNT_MAX = (ITERS > RST_CYC) ? ITERS : RST_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_m;
  logic [WIDTH:0]   r_x, r_y, r_z;
  logic [WIDTH:0]   r_rsp_x, r_rsp_y, r_rsp_z;
  logic [15:0]      r_job_cnt;
  logic             w_accept;
  logic             w_load_last;
  logic             w_run_last;
  logic             w_rsp_take;

  assign w_accept    = (r_state == S_IDLE) && req_valid;
  assign w_load_last = (r_state == S_LOAD) && (r_cnt == LOAD_LAST);
  assign w_run_last  = (r_state == S_RUN)  && (r_cnt == RUN_LAST);
  assign w_rsp_take  = (r_state == S_DONE) && rsp_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_state_next = S_LOAD;
      S_LOAD:  if (w_load_last) w_state_next = S_RUN;
      S_RUN:   if (w_run_last)  w_state_next = S_DONE;
      S_DONE:  if (w_rsp_take)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // recon sits in reset everywhere except RUN, so its outputs only evolve then.
  always_comb begin
    req_ready    = 1'b0;
    cordic_reset = 1'b1;
    rsp_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_RUN:   cordic_reset = 1'b0;
      S_DONE:  rsp_valid    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_m       <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_rsp_x   <= '0;
      r_rsp_y   <= '0;
      r_rsp_z   <= '0;
      r_job_cnt <= '0;
    end else begin
      if (w_accept || w_load_last || w_run_last) begin
        r_cnt <= '0;
      end else if (r_state == S_LOAD || r_state == S_RUN) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_m <= req_m;
        r_x <= req_x;
        r_y <= req_y;
        r_z <= req_z;
      end
      if (w_run_last) begin
        r_rsp_x <= cordic_xout;
        r_rsp_y <= cordic_yout;
        r_rsp_z <= cordic_zout;
      end
      if (w_rsp_take) begin
        r_job_cnt <= r_job_cnt + 16'd1;
      end
    end
  end

  assign cordic_m = r_m;
  assign cordic_x = r_x;
  assign cordic_y = r_y;
  assign cordic_z = r_z;
  assign rsp_x    = r_rsp_x;
  assign rsp_y    = r_rsp_y;
  assign rsp_z    = r_rsp_z;
  assign job_cnt  = r_job_cnt;

endmodule
